axi_trace_decoder: RTL



---
 rtl/trace_fmt_pkg.sv | 53 +++++
 rtl/axi_trace_decoder_if.sv | 49 ++++
 rtl/trace_beat_assembler.sv | 77 +++++++
 rtl/axi_trace_decoder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/trace_fmt_pkg.sv
// Trace package geometry shared by the trace encoder and decoder: beat size,
// derived package length/beat count, and field offsets (AR..B, MSB to LSB).
package trace_fmt_pkg;

  localparam int BEAT_W = 512;
  localparam int KEEP_W = 64;
  localparam int NUM_CH = 5;

  // Also the bit index of each channel in the pending mask.
  typedef enum logic [2:0] {
    CH_AR = 3'd0,
    CH_AW = 3'd1,
    CH_R  = 3'd2,
    CH_W  = 3'd3,
    CH_B  = 3'd4
  } chan_e;

  localparam int DEF_A_W = 64;
  localparam int DEF_R_W = 64;
  localparam int DEF_W_W = 64;
  localparam int DEF_B_W = 64;

  function automatic int package_len(input int a_w, input int r_w,
                                     input int w_w, input int b_w);
    return 2 * a_w + r_w + w_w + b_w;
  endfunction

  function automatic int package_beats(input int a_w, input int r_w,
                                       input int w_w, input int b_w);
    return (package_len(a_w, r_w, w_w, b_w) + BEAT_W - 1) / BEAT_W;
  endfunction

  function automatic int field_lsb(input chan_e ch, input int a_w, input int r_w,
                                   input int w_w, input int b_w);
    int lsb;
    case (ch)
      CH_B:    lsb = 0;
      CH_W:    lsb = b_w;
      CH_R:    lsb = b_w + w_w;
      CH_AW:   lsb = b_w + w_w + r_w;
      CH_AR:   lsb = b_w + w_w + r_w + a_w;
      default: lsb = 0;
    endcase
    return lsb;
  endfunction

  localparam int B_LSB  = 0;
  localparam int W_LSB  = B_LSB + DEF_B_W;
  localparam int R_LSB  = W_LSB + DEF_W_W;
  localparam int AW_LSB = R_LSB + DEF_R_W;
  localparam int AR_LSB = AW_LSB + DEF_A_W;

endpackage

// File: rtl/axi_trace_decoder_if.sv
// Trace beat input plus the five per-channel record outputs of the decoder.
interface axi_trace_decoder_if
  import trace_fmt_pkg::*;
#(
  parameter int A_W = 64,
  parameter int R_W = 64,
  parameter int W_W = 64,
  parameter int B_W = 64
);
  logic              i_valid;
  logic              i_ready;
  logic [BEAT_W-1:0] i_data;
  logic [KEEP_W-1:0] i_keep;
  logic              i_last;

  logic           ar_valid;
  logic           ar_ready;
  logic [A_W-1:0] ar_payload;
  logic           aw_valid;
  logic           aw_ready;
  logic [A_W-1:0] aw_payload;
  logic           r_valid;
  logic           r_ready;
  logic [R_W-1:0] r_payload;
  logic           w_valid;
  logic           w_ready;
  logic [W_W-1:0] w_payload;
  logic           b_valid;
  logic           b_ready;
  logic [B_W-1:0] b_payload;

  // Trace source / record sinks.
  modport master (
    output i_valid, i_data, i_keep, i_last,
    output ar_ready, aw_ready, r_ready, w_ready, b_ready,
    input  i_ready,
    input  ar_valid, ar_payload, aw_valid, aw_payload, r_valid, r_payload,
    input  w_valid, w_payload, b_valid, b_payload
  );

  // Decoder side.
  modport slave (
    input  i_valid, i_data, i_keep, i_last,
    input  ar_ready, aw_ready, r_ready, w_ready, b_ready,
    output i_ready,
    output ar_valid, ar_payload, aw_valid, aw_payload, r_valid, r_payload,
    output w_valid, w_payload, b_valid, b_payload
  );
endinterface

// File: rtl/trace_beat_assembler.sv
// Shifts trace beats into the package buffer (first beat ends up on top),
// counts beats, flags keep/truncation errors and pulses on a completed package.
module trace_beat_assembler
  import trace_fmt_pkg::*;
#(
  parameter int BEATS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    beat_accept,
  input  logic [BEAT_W-1:0]       beat_data,
  input  logic [KEEP_W-1:0]       beat_keep,
  input  logic                    beat_last,
  output logic                    pkg_done,
  output logic [BEATS*BEAT_W-1:0] pkg_buf,
  output logic [BEATS*BEAT_W-1:0] pkg_buf_next,
  output logic [1:0]              err
);
  localparam int BUF_W = BEATS * BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BUF_W-1:0] pkg_buf_q, pkg_buf_d;
  logic [1:0]       err_q, err_d;
  logic [BUF_W-1:0] shifted;
  logic             final_beat;

  generate
    if (BEATS == 1) begin : g_single
      assign shifted = beat_data;
    end else begin : g_multi
      assign shifted = {pkg_buf_q[BUF_W-BEAT_W-1:0], beat_data};
    end
  endgenerate

  assign final_beat = beat_accept && (beat_cnt_q == LAST_IDX);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkg_buf_d  = pkg_buf_q;
    err_d      = err_q;
    if (beat_accept) begin
      // Bad keep is only reported; the beat is still used as-is.
      pkg_buf_d = shifted;
      if (beat_keep != '1) begin
        err_d[0] = 1'b1;
      end
      if (final_beat || beat_last) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
      if (beat_last && !final_beat) begin
        err_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      pkg_buf_q  <= '0;
      err_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      pkg_buf_q  <= pkg_buf_d;
      err_q      <= err_d;
    end
  end

  assign pkg_done     = final_beat;
  assign pkg_buf      = pkg_buf_q;
  assign pkg_buf_next = pkg_buf_d;
  assign err          = err_q;

endmodule

// File: rtl/axi_trace_decoder.sv
// Receive side of the AXI trace path: reassembles trace packages and splits
// them into AR/AW/R/W/B records, each drained on its own valid/ready port.
module axi_trace_decoder
  import trace_fmt_pkg::*;
#(
  parameter int A_PAYLOAD_FORMATTED_WIDTH = DEF_A_W,
  parameter int R_PAYLOAD_FORMATTED_WIDTH = DEF_R_W,
  parameter int W_PAYLOAD_FORMATTED_WIDTH = DEF_W_W,
  parameter int B_PAYLOAD_FORMATTED_WIDTH = DEF_B_W
) (
  input  logic                clk,
  input  logic                rst,
  axi_trace_decoder_if.slave  bus,
  output logic [31:0]         pkg_count,
  output logic [1:0]          err
);
  localparam int A_W     = A_PAYLOAD_FORMATTED_WIDTH;
  localparam int R_W     = R_PAYLOAD_FORMATTED_WIDTH;
  localparam int W_W     = W_PAYLOAD_FORMATTED_WIDTH;
  localparam int B_W     = B_PAYLOAD_FORMATTED_WIDTH;
  localparam int PKG_LEN = package_len(A_W, R_W, W_W, B_W);
  localparam int BEATS   = package_beats(A_W, R_W, W_W, B_W);
  localparam int BUF_W   = BEATS * BEAT_W;

  // The default geometry uses the exact offsets the encoder is built with.
  localparam bit DEFAULT_GEOM = (A_W == DEF_A_W) && (R_W == DEF_R_W) &&
                                (W_W == DEF_W_W) && (B_W == DEF_B_W);
  localparam int AR_LSB_P = DEFAULT_GEOM ? AR_LSB : field_lsb(CH_AR, A_W, R_W, W_W, B_W);
  localparam int AW_LSB_P = DEFAULT_GEOM ? AW_LSB : field_lsb(CH_AW, A_W, R_W, W_W, B_W);
  localparam int R_LSB_P  = DEFAULT_GEOM ? R_LSB  : field_lsb(CH_R,  A_W, R_W, W_W, B_W);
  localparam int W_LSB_P  = DEFAULT_GEOM ? W_LSB  : field_lsb(CH_W,  A_W, R_W, W_W, B_W);
  localparam int B_LSB_P  = DEFAULT_GEOM ? B_LSB  : field_lsb(CH_B,  A_W, R_W, W_W, B_W);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [31:0]       pkg_count_q, pkg_count_d;

  logic              beat_accept;
  logic              pkg_done;
  logic [BUF_W-1:0]  pkg_buf;
  logic [BUF_W-1:0]  pkg_buf_next;
  logic [NUM_CH-1:0] present_next;
  logic [NUM_CH-1:0] ready_vec;
  logic [NUM_CH-1:0] fire;

  assign bus.i_ready = (state_q == ST_COLLECT);
  assign beat_accept = bus.i_valid && bus.i_ready;

  trace_beat_assembler #(
    .BEATS (BEATS)
  ) u_assembler (
    .clk          (clk),
    .rst          (rst),
    .beat_accept  (beat_accept),
    .beat_data    (bus.i_data),
    .beat_keep    (bus.i_keep),
    .beat_last    (bus.i_last),
    .pkg_done     (pkg_done),
    .pkg_buf      (pkg_buf),
    .pkg_buf_next (pkg_buf_next),
    .err          (err)
  );

  // Presence is judged on the buffer as it will be after the final beat, so
  // records are valid the cycle right after that beat is accepted.
  assign present_next[CH_AR] = |pkg_buf_next[AR_LSB_P +: A_W];
  assign present_next[CH_AW] = |pkg_buf_next[AW_LSB_P +: A_W];
  assign present_next[CH_R]  = |pkg_buf_next[R_LSB_P  +: R_W];
  assign present_next[CH_W]  = |pkg_buf_next[W_LSB_P  +: W_W];
  assign present_next[CH_B]  = |pkg_buf_next[B_LSB_P  +: B_W];

  assign ready_vec[CH_AR] = bus.ar_ready;
  assign ready_vec[CH_AW] = bus.aw_ready;
  assign ready_vec[CH_R]  = bus.r_ready;
  assign ready_vec[CH_W]  = bus.w_ready;
  assign ready_vec[CH_B]  = bus.b_ready;

  assign fire = pending_q & ready_vec;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    pkg_count_d = pkg_count_q;
    if (state_q == ST_COLLECT) begin
      if (pkg_done) begin
        pending_d = present_next;
        if (present_next == '0) begin
          pkg_count_d = pkg_count_q + 32'd1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
    end else begin
      pending_d = pending_q & ~fire;
      if (pending_d == '0) begin
        pkg_count_d = pkg_count_q + 32'd1;
        state_d     = ST_COLLECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      pending_q   <= '0;
      pkg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pkg_count_q <= pkg_count_d;
    end
  end

  assign bus.ar_valid   = pending_q[CH_AR];
  assign bus.aw_valid   = pending_q[CH_AW];
  assign bus.r_valid    = pending_q[CH_R];
  assign bus.w_valid    = pending_q[CH_W];
  assign bus.b_valid    = pending_q[CH_B];

  assign bus.ar_payload = pending_q[CH_AR] ? pkg_buf[AR_LSB_P +: A_W] : '0;
  assign bus.aw_payload = pending_q[CH_AW] ? pkg_buf[AW_LSB_P +: A_W] : '0;
  assign bus.r_payload  = pending_q[CH_R]  ? pkg_buf[R_LSB_P  +: R_W] : '0;
  assign bus.w_payload  = pending_q[CH_W]  ? pkg_buf[W_LSB_P  +: W_W] : '0;
  assign bus.b_payload  = pending_q[CH_B]  ? pkg_buf[B_LSB_P  +: B_W] : '0;

  assign pkg_count = pkg_count_q;

  // Pad bits above the package are deliberately ignored.
  generate
    if (PKG_LEN < BUF_W) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^{pkg_buf[BUF_W-1:PKG_LEN], pkg_buf_next[BUF_W-1:PKG_LEN]};
    end
  endgenerate

endmodule
